// File: rtl/mealy_stimulus_serializer.sv
// ============================================================================
//  Module   : mealy_stimulus_serializer
//  Purpose  : Upstream stimulus stage for the Mealy pattern detector. Takes a
//             parallel pattern plus length through a valid/ready load
//             handshake and plays it MSB-first, one bit per clock, with
//             one-shot or continuous-repeat playback, abort and an
//             end-of-stream done pulse.
//  Options  : MEALY_SERIALIZER_PARITY_EN - append an even-parity bit after
//             the data bits of every repetition (done moves to it).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mealy_stimulus_serializer #(
   parameter int WIDTH = 9,
   parameter int LEN_W = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic [LEN_W-1:0] load_len,
   input  logic             repeat_en,
   input  logic             abort,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             done,
   output logic             busy
);

`ifdef MEALY_SERIALIZER_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   // Frame = data bits (+ optional parity bit), left-aligned in FW bits.
   localparam int               FW          = WIDTH + PAR;
   localparam int               CNT_W       = LEN_W + 1;
   localparam logic [LEN_W-1:0] C_WIDTH_LEN = LEN_W'(WIDTH);
   localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_CNT_TWO   = CNT_W'(2);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t             r_state;
   logic [FW-1:0]      r_shreg;     // bits still to be presented, MSB next
   logic [FW-1:0]      r_copy;      // full frame kept for repeat playback
   logic [CNT_W-1:0]   r_cnt;       // bits left including the one on bit_out
   logic [CNT_W-1:0]   r_flen;      // frame length for repeat reload
   logic               r_rep;
   logic               r_load_ready;
   logic               r_bit_out;
   logic               r_bit_valid;
   logic               r_done;
   logic               r_busy;

   logic [LEN_W-1:0]   w_len;
   logic [LEN_W-1:0]   w_shamt;
   logic [FW-1:0]      w_frame;
   logic [CNT_W-1:0]   w_flen;
`ifdef MEALY_SERIALIZER_PARITY_EN
   logic [WIDTH-1:0]   w_mask;
   logic               w_par;
`endif

   // Clamp the requested length and build the left-aligned frame to load.
   always_comb begin
      w_len   = (load_len > C_WIDTH_LEN) ? C_WIDTH_LEN : load_len;
      w_shamt = C_WIDTH_LEN - w_len;
`ifdef MEALY_SERIALIZER_PARITY_EN
      w_mask  = ~({WIDTH{1'b1}} << w_len);
      w_par   = ^(load_data & w_mask);
      // Shifting discards the unused upper data bits and places parity
      // directly behind the last data bit.
      w_frame = {load_data, w_par} << w_shamt;
      w_flen  = CNT_W'(w_len) + C_CNT_ONE;
`else
      w_frame = load_data << w_shamt;
      w_flen  = CNT_W'(w_len);
`endif
   end

   // Load/shift state machine; every output is registered here.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_shreg      <= '0;
         r_copy       <= '0;
         r_cnt        <= '0;
         r_flen       <= '0;
         r_rep        <= 1'b0;
         r_load_ready <= 1'b1;
         r_bit_out    <= 1'b0;
         r_bit_valid  <= 1'b0;
         r_done       <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_bit_out    <= 1'b0;
               r_bit_valid  <= 1'b0;
               r_done       <= 1'b0;
               r_busy       <= 1'b0;
               r_load_ready <= 1'b1;
               if (load_valid) begin
                  r_copy <= w_frame;
                  r_flen <= w_flen;
                  r_rep  <= repeat_en;
                  if (w_len == '0) begin
                     // Empty pattern: nothing to emit, just signal completion.
                     r_done <= 1'b1;
                  end else begin
                     // First bit goes out at the accepting edge itself.
                     r_state      <= S_SHIFT;
                     r_shreg      <= w_frame << 1;
                     r_cnt        <= w_flen;
                     r_bit_out    <= w_frame[FW-1];
                     r_bit_valid  <= 1'b1;
                     r_done       <= (w_flen == C_CNT_ONE) && !repeat_en;
                     r_busy       <= 1'b1;
                     r_load_ready <= 1'b0;
                  end
               end
            end

            S_SHIFT: begin
               if (abort || (r_cnt == C_CNT_ONE && !r_rep)) begin
                  // Abort wins over a repeat reload; remaining bits dropped.
                  r_state      <= S_IDLE;
                  r_bit_out    <= 1'b0;
                  r_bit_valid  <= 1'b0;
                  r_done       <= 1'b0;
                  r_busy       <= 1'b0;
                  r_load_ready <= 1'b1;
               end else if (r_cnt == C_CNT_ONE) begin
                  // Seamless restart of the saved frame; repeat never ends in done.
                  r_shreg   <= r_copy << 1;
                  r_cnt     <= r_flen;
                  r_bit_out <= r_copy[FW-1];
                  r_done    <= 1'b0;
               end else begin
                  r_shreg   <= r_shreg << 1;
                  r_cnt     <= r_cnt - C_CNT_ONE;
                  r_bit_out <= r_shreg[FW-1];
                  r_done    <= (r_cnt == C_CNT_TWO) && !r_rep;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign load_ready = r_load_ready;
   assign bit_out    = r_bit_out;
   assign bit_valid  = r_bit_valid;
   assign done       = r_done;
   assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_mealy_stimulus_serializer.sv
// ============================================================================
//  Module   : tb_mealy_stimulus_serializer
//  Purpose  : Directed self-checking bench for mealy_stimulus_serializer
//             (default build, parity bit disabled).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mealy_stimulus_serializer;

   logic       clock;
   logic       reset_n;
   logic       load_valid;
   logic       load_ready;
   logic [8:0] load_data;
   logic [3:0] load_len;
   logic       repeat_en;
   logic       abort;
   logic       bit_out;
   logic       bit_valid;
   logic       done;
   logic       busy;

   int n_total;
   int n_bad;

   mealy_stimulus_serializer #(.WIDTH(9), .LEN_W(4)) u_dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_len   (load_len),
      .repeat_en  (repeat_en),
      .abort      (abort),
      .bit_out    (bit_out),
      .bit_valid  (bit_valid),
      .done       (done),
      .busy       (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Advance one rising edge, then settle so inputs change and outputs are
   // sampled away from the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Full output vector check: {load_ready, busy, done, bit_valid, bit_out}.
   task automatic check_out(input string tag, input logic [4:0] exp);
      check(tag, {27'd0, load_ready, busy, done, bit_valid, bit_out}, {27'd0, exp});
   endtask

   logic [8:0] pat1;
   logic [6:0] seq2;

   initial begin
      n_total    = 0;
      n_bad      = 0;
      reset_n    = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      load_len   = '0;
      repeat_en  = 1'b0;
      abort      = 1'b0;
      pat1       = 9'b101001101;
      seq2       = 7'b1011011;

      tick();
      tick();
      check_out("reset", 5'b10000);
      reset_n = 1'b1;
      tick();
      check_out("idle_after_reset", 5'b10000);

      // 1: one-shot, 9 bits, done only on the last bit.
      load_valid = 1'b1; load_data = pat1; load_len = 4'd9; repeat_en = 1'b0;
      tick();
      load_valid = 1'b0;
      for (int j = 0; j < 9; j++) begin
         check_out($sformatf("t1_bit%0d", j), {1'b0, 1'b1, (j == 8), 1'b1, pat1[8-j]});
         tick();
      end
      check_out("t1_end", 5'b10000);

      // 2: repeat of 3'b101, abort while the 7th bit is shown.
      load_valid = 1'b1; load_data = 9'h005; load_len = 4'd3; repeat_en = 1'b1;
      tick();
      load_valid = 1'b0; repeat_en = 1'b0;
      for (int j = 0; j < 7; j++) begin
         check_out($sformatf("t2_bit%0d", j), {1'b0, 1'b1, 1'b0, 1'b1, seq2[6-j]});
         if (j == 6) abort = 1'b1;
         tick();
      end
      abort = 1'b0;
      check_out("t2_abort", 5'b10000);

      // 3a: zero length -> single done pulse, no bits.
      load_valid = 1'b1; load_data = 9'h1FF; load_len = 4'd0;
      tick();
      load_valid = 1'b0;
      check_out("t3_len0_done", 5'b10100);
      tick();
      check_out("t3_len0_after", 5'b10000);

      // 3b: length 15 clamps to 9.
      load_valid = 1'b1; load_data = pat1; load_len = 4'd15;
      tick();
      load_valid = 1'b0;
      for (int j = 0; j < 9; j++) begin
         check_out($sformatf("t3_clamp_bit%0d", j), {1'b0, 1'b1, (j == 8), 1'b1, pat1[8-j]});
         tick();
      end
      check_out("t3_clamp_end", 5'b10000);

      // 4: reset during the 4th bit, then a fresh load.
      load_valid = 1'b1; load_data = pat1; load_len = 4'd9;
      tick();
      load_valid = 1'b0;
      for (int j = 0; j < 3; j++) tick();
      check_out("t4_bit3", {1'b0, 1'b1, 1'b0, 1'b1, pat1[5]});
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check_out("t4_reset", 5'b10000);
      load_valid = 1'b1; load_data = 9'h003; load_len = 4'd2;
      tick();
      load_valid = 1'b0;
      check_out("t4_new_bit0", 5'b01011);
      tick();
      check_out("t4_new_bit1", 5'b01111);
      tick();
      check_out("t4_new_end", 5'b10000);

      // 5: load_valid held high with changing data while shifting.
      load_valid = 1'b1; load_data = 9'h1FF; load_len = 4'd2;
      tick();
      check_out("t5_bit0", 5'b01011);
      load_data = 9'h000; load_len = 4'd1;
      tick();
      check_out("t5_bit1", 5'b01111);
      load_data = 9'h006; load_len = 4'd3;
      tick();
      check_out("t5_idle", 5'b10000);
      tick();
      load_valid = 1'b0;
      check_out("t5_new_bit0", 5'b01011);
      tick();
      check_out("t5_new_bit1", 5'b01011);
      tick();
      check_out("t5_new_bit2", 5'b01110);
      tick();
      check_out("t5_new_end", 5'b10000);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
